movement_control: RTL and testbench



---
 rtl/duck_pkg.sv | 47 ++++
 rtl/frame_ticker.sv | 32 +++
 rtl/movement_control.sv | 123 ++++++++++++
 tb/tb_movement_control.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// duck_pkg: state/control codes shared between the movement sequencer and the
// movement datapath, the default frame length, and the direction decode helpers.
// Ports: none (package).
package duck_pkg;

   // Each code is both the sequencer state and the datapath control word.
   typedef enum logic [3:0] {
      ST_HOLD    = 4'b0000,
      ST_CLEAR   = 4'b0001,
      ST_RIGHT   = 4'b0010,
      ST_LEFT    = 4'b0011,
      ST_PREHOLD = 4'b0100,
      ST_DRAW    = 4'b0101,
      ST_DOWN    = 4'b0110,
      ST_UP      = 4'b0111
   } state_t;

   // 60 Hz frame at a 50 MHz clock.
   localparam int DEFAULT_TICK_CYCLES = 833334;

   // Bit positions inside the latched direction vector.
   localparam int DIR_LEFT  = 0;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_UP    = 2;
   localparam int DIR_DOWN  = 3;

   // Vertical step to take, or DRAW when none. Up and down together cancel.
   function automatic state_t vert_step(input logic [3:0] dir);
      if (dir[DIR_DOWN] && !dir[DIR_UP])
         return ST_DOWN;
      else if (dir[DIR_UP] && !dir[DIR_DOWN])
         return ST_UP;
      else
         return ST_DRAW;
   endfunction

   // First step after the clear sweep: horizontal first, then vertical.
   function automatic state_t horiz_step(input logic [3:0] dir);
      if (dir[DIR_LEFT] && !dir[DIR_RIGHT])
         return ST_LEFT;
      else if (dir[DIR_RIGHT] && !dir[DIR_LEFT])
         return ST_RIGHT;
      else
         return vert_step(dir);
   endfunction

endpackage

// File: rtl/frame_ticker.sv
// frame_ticker: free-running frame counter 0 .. TICK_CYCLES-1.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   frame_tick out  high for the one cycle the counter holds TICK_CYCLES-1
module frame_ticker
   import duck_pkg::*;
#(
   parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
   parameter int CTR_W       = 20
) (
   input  logic clk,
   input  logic reset,
   output logic frame_tick
);

   localparam logic [CTR_W-1:0] LAST = CTR_W'(TICK_CYCLES - 1);

   logic [CTR_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CTR_W'(1);
   end

   assign frame_tick = (cnt == LAST);

endmodule

// File: rtl/movement_control.sv
// movement_control: per-sprite frame sequencer in front of the movement datapath.
// Each frame: clear sweep, at most one horizontal and one vertical pixel step,
// redraw sweep. The datapath's enable comes back as `done` (sweep complete).
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   go_left/go_right/go_up/go_down     level direction requests
//   done                               sweep-complete from the datapath
//   control[3:0]                       state code to the datapath (the state register)
//   frame_tick                         one-cycle pulse at frame-counter wrap
//   overrun                            tick arrived while one was still pending
//   busy                               high outside PREHOLD/HOLD
//
// state   | meaning
// PREHOLD | after reset, waiting for the first tick (no direction latch)
// HOLD    | idle between frames; tick latches directions
// CLEAR   | datapath erasing sprite at current position
// LEFT    | one-cycle horizontal step left
// RIGHT   | one-cycle horizontal step right
// DOWN    | one-cycle vertical step down
// UP      | one-cycle vertical step up
// DRAW    | datapath redrawing sprite at new position
module movement_control
   import duck_pkg::*;
#(
   parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
   parameter int CTR_W       = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go_left,
   input  logic       go_right,
   input  logic       go_up,
   input  logic       go_down,
   input  logic       done,
   output logic [3:0] control,
   output logic       frame_tick,
   output logic       overrun,
   output logic       busy
);

   state_t     state;
   logic [3:0] dir_q;
   logic       first;
   logic       tick_pend;

   logic       idle;
   logic       in_sweep;
   logic       tick_avail;
   logic       consume;
   logic       done_ok;
   state_t     h_next;
   state_t     v_next;

   frame_ticker #(
      .TICK_CYCLES (TICK_CYCLES),
      .CTR_W       (CTR_W)
   ) u_ticker (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick)
   );

   assign idle       = (state == ST_PREHOLD) || (state == ST_HOLD);
   assign in_sweep   = (state == ST_CLEAR) || (state == ST_DRAW);
   assign tick_avail = tick_pend | frame_tick;
   assign consume    = idle & tick_avail;
   // enable is still high from the previous state on a sweep's first cycle
   assign done_ok    = done & ~first & in_sweep;
   assign h_next     = horiz_step(dir_q);
   assign v_next     = vert_step(dir_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_PREHOLD;
         dir_q     <= 4'b0000;
         first     <= 1'b0;
         tick_pend <= 1'b0;
      end else begin
         first <= 1'b0;
         // a fresh tick landing on the consume cycle refills the flag
         tick_pend <= consume ? (tick_pend & frame_tick) : tick_avail;
         case (state)
            ST_PREHOLD: begin
               if (tick_avail) begin
                  state <= ST_CLEAR;
                  first <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (tick_avail) begin
                  state <= ST_CLEAR;
                  first <= 1'b1;
                  dir_q <= {go_down, go_up, go_right, go_left};
               end
            end
            ST_CLEAR: begin
               if (done_ok) begin
                  state <= h_next;
                  first <= (h_next == ST_DRAW);
               end
            end
            ST_LEFT, ST_RIGHT: begin
               state <= v_next;
               first <= (v_next == ST_DRAW);
            end
            ST_DOWN, ST_UP: begin
               state <= ST_DRAW;
               first <= 1'b1;
            end
            ST_DRAW: begin
               if (done_ok)
                  state <= ST_HOLD;
            end
            default: state <= ST_PREHOLD;
         endcase
      end
   end

   assign control = state;
   assign busy    = ~idle;
   assign overrun = frame_tick & tick_pend & ~consume;

endmodule

// File: tb/tb_movement_control.sv
module tb_movement_control;
   import duck_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       go_left = 1'b0, go_right = 1'b0, go_up = 1'b0, go_down = 1'b0;
   logic       done = 1'b0;
   logic [3:0] control;
   logic       frame_tick, overrun, busy;

   int vecs = 0;
   int errs = 0;
   logic [3:0] trace [32];

   always #5 clk = ~clk;

   movement_control #(.TICK_CYCLES(16), .CTR_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .go_left    (go_left),
      .go_right   (go_right),
      .go_up      (go_up),
      .go_down    (go_down),
      .done       (done),
      .control    (control),
      .frame_tick (frame_tick),
      .overrun    (overrun),
      .busy       (busy)
   );

   // Advance one cycle; sample point is 1 time unit after the edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 0 (counter = 0) with reset released.
   task automatic do_reset;
      reset = 1'b1;
      step;
      step;
      reset = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (frame_tick !== 1'b1 && n < 40) begin
         step;
         n++;
      end
   endtask

   // Records control for n cycles while driving done from pat.
   task automatic play(input int n, input logic [31:0] pat);
      for (int i = 0; i < n; i++) begin
         trace[i] = control;
         done = pat[i];
         step;
      end
      done = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      logic [3:0] exp_seq [5] = '{ST_CLEAR, ST_CLEAR, ST_DRAW, ST_DRAW, ST_HOLD};
      do_reset;
      done = 1'b1;
      vecs++; if (control !== ST_PREHOLD) begin errs++; $display("FAIL rst_control: got %b expected %b", control, ST_PREHOLD); end
      vecs++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL rst_tick: got %b expected 0", frame_tick); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", busy); end
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
      wait_tick(n);
      vecs++; if (n != 15) begin errs++; $display("FAIL first_tick_cycle: got %0d expected 15", n); end
      vecs++; if (control !== ST_PREHOLD) begin errs++; $display("FAIL prehold_at_tick: got %b expected %b", control, ST_PREHOLD); end
      step;
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_clear: got %b expected 1", busy); end
      play(5, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         vecs++;
         if (trace[i] !== exp_seq[i]) begin errs++; $display("FAIL reset_seq[%0d]: got %b expected %b", i, trace[i], exp_seq[i]); end
      end
   endtask

   task automatic test_diagonal;
      int n;
      logic [3:0] exp_seq [13] = '{ST_CLEAR, ST_CLEAR, ST_CLEAR, ST_CLEAR, ST_CLEAR,
                                   ST_RIGHT, ST_UP,
                                   ST_DRAW, ST_DRAW, ST_DRAW, ST_DRAW, ST_DRAW, ST_HOLD};
      go_right = 1'b1;
      go_up    = 1'b1;
      wait_tick(n);
      vecs++; if (n >= 40) begin errs++; $display("FAIL diag_tick_timeout: got %0d steps expected <40", n); end
      vecs++; if (control !== ST_HOLD) begin errs++; $display("FAIL diag_hold_at_tick: got %b expected %b", control, ST_HOLD); end
      step;
      play(13, 32'h0000_0810);
      for (int i = 0; i < 13; i++) begin
         vecs++;
         if (trace[i] !== exp_seq[i]) begin errs++; $display("FAIL diag_seq[%0d]: got %b expected %b", i, trace[i], exp_seq[i]); end
      end
      go_right = 1'b0;
      go_up    = 1'b0;
   endtask

   task automatic test_cancel;
      int n;
      logic [3:0] exp_seq [6] = '{ST_CLEAR, ST_CLEAR, ST_DOWN, ST_DRAW, ST_DRAW, ST_HOLD};
      go_left  = 1'b1;
      go_right = 1'b1;
      go_down  = 1'b1;
      wait_tick(n);
      vecs++; if (control !== ST_HOLD) begin errs++; $display("FAIL cancel_hold_at_tick: got %b expected %b", control, ST_HOLD); end
      step;
      play(6, 32'h0000_0012);
      for (int i = 0; i < 6; i++) begin
         vecs++;
         if (trace[i] !== exp_seq[i]) begin errs++; $display("FAIL cancel_seq[%0d]: got %b expected %b", i, trace[i], exp_seq[i]); end
      end
      go_left  = 1'b0;
      go_right = 1'b0;
      go_down  = 1'b0;
   endtask

   task automatic test_dir_toggle;
      int n;
      logic [3:0] exp_seq [6] = '{ST_CLEAR, ST_CLEAR, ST_LEFT, ST_DRAW, ST_DRAW, ST_HOLD};
      go_left = 1'b1;
      wait_tick(n);
      vecs++; if (control !== ST_HOLD) begin errs++; $display("FAIL toggle_hold_at_tick: got %b expected %b", control, ST_HOLD); end
      step;
      go_left  = 1'b0;
      go_right = 1'b1;
      go_up    = 1'b1;
      play(6, 32'h0000_0012);
      for (int i = 0; i < 6; i++) begin
         vecs++;
         if (trace[i] !== exp_seq[i]) begin errs++; $display("FAIL toggle_seq[%0d]: got %b expected %b", i, trace[i], exp_seq[i]); end
      end
      go_right = 1'b0;
      go_up    = 1'b0;
   endtask

   // Tick at 15 starts the frame, DRAW is entered at 18 and starved for 40
   // cycles: tick 31 becomes pending, tick 47 finds it pending -> one overrun.
   task automatic test_overrun;
      int n;
      int ov_cnt = 0;
      int ov_cyc = -1;
      int bad_state = 0;
      do_reset;
      done = 1'b1;
      wait_tick(n);
      step;
      step;
      step;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (overrun === 1'b1) begin
            ov_cnt++;
            ov_cyc = 18 + i;
         end
         if (control !== ST_DRAW) bad_state++;
         step;
      end
      vecs++; if (ov_cnt != 1) begin errs++; $display("FAIL overrun_count: got %0d expected 1", ov_cnt); end
      vecs++; if (ov_cyc != 47) begin errs++; $display("FAIL overrun_cycle: got %0d expected 47", ov_cyc); end
      vecs++; if (bad_state != 0) begin errs++; $display("FAIL draw_held: got %0d non-DRAW cycles expected 0", bad_state); end
      done = 1'b1;
      step;
      vecs++; if (control !== ST_HOLD) begin errs++; $display("FAIL overrun_hold: got %b expected %b", control, ST_HOLD); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL overrun_hold_busy: got %b expected 0", busy); end
      done = 1'b0;
      step;
      vecs++; if (control !== ST_CLEAR) begin errs++; $display("FAIL pending_start: got %b expected %b", control, ST_CLEAR); end
   endtask

   task automatic test_reset_mid_draw;
      int n;
      do_reset;
      done = 1'b1;
      wait_tick(n);
      step;
      step;
      step;
      done = 1'b0;
      step;
      step;
      vecs++; if (control !== ST_DRAW) begin errs++; $display("FAIL mid_draw: got %b expected %b", control, ST_DRAW); end
      reset = 1'b1;
      step;
      reset = 1'b0;
      vecs++; if (control !== ST_PREHOLD) begin errs++; $display("FAIL mid_rst_control: got %b expected %b", control, ST_PREHOLD); end
      vecs++; if (dut.u_ticker.cnt !== 4'd0) begin errs++; $display("FAIL mid_rst_counter: got %0d expected 0", dut.u_ticker.cnt); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
      vecs++; if (dut.tick_pend !== 1'b0) begin errs++; $display("FAIL mid_rst_pend: got %b expected 0", dut.tick_pend); end
      wait_tick(n);
      vecs++; if (n != 15) begin errs++; $display("FAIL mid_rst_next_tick: got %0d expected 15", n); end
      vecs++; if (control !== ST_PREHOLD) begin errs++; $display("FAIL mid_rst_prehold: got %b expected %b", control, ST_PREHOLD); end
   endtask

   initial begin
      test_reset;
      test_diagonal;
      test_cancel;
      test_dir_toggle;
      test_overrun;
      test_reset_mid_draw;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
